// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding, width limit and counter helpers
// for the bit-serial adder controller.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam int MAX_WIDTH = 32;

   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   // Ripple increment of a 5-bit count built from bitwise logic only.
   function automatic logic [4:0] inc5(input logic [4:0] x);
      return x ^ {&x[3:0], &x[2:0], &x[1:0], x[0], 1'b1};
   endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds a+b+cin one bit per clock, LSB first, on one shared full_adder.
// Defining SERIAL_ADDER_SUB_EN adds a sub port that turns the operation into a-b.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   import serial_adder_pkg::*;

   localparam int CW = cnt_w(WIDTH);

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, b_ld;
   logic [CW-1:0]    bit_cnt;
   logic             carry, c_ld, fa_s, fa_co, accept, last;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: invert b and force the initial carry.
   assign b_ld = sub ? ~b : b;
   assign c_ld = sub | cin;
`else
   assign b_ld = b;
   assign c_ld = cin;
`endif

   full_adder u_fa (
      .a (a_sh[0]),
      .b (b_sh[0]),
      .ci(carry),
      .s (fa_s),
      .co(fa_co)
   );

   assign accept = in_valid && in_ready;
   assign last   = bit_cnt == CW'(WIDTH - 1);
   assign sum    = res_sh;
   assign cout   = carry;

   always_comb begin
      state_nx  = state;
      in_ready  = state == IDLE;
      busy      = state == RUN;
      out_valid = state == DONE;
      unique case (state)
         IDLE:    if (in_valid) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         carry   <= 1'b0;
         bit_cnt <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_sh    <= a;
            b_sh    <= b_ld;
            carry   <= c_ld;
            bit_cnt <= '0;
         end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= WIDTH'({fa_s, res_sh} >> 1);
            carry   <= fa_co;
            bit_cnt <= CW'(inc5(5'(bit_cnt)));
         end
      end

endmodule
